// File: rtl/warp_scheduler.sv
// Round-robin warp scheduler: owns per-warp PC and done state and sequences the
// shared fetch/decode/execute datapath one granted warp at a time.
package warp_scheduler_pkg;
  typedef enum logic [2:0] {
    WARP_IDLE, WARP_FETCH, WARP_DECODE, WARP_REQUEST,
    WARP_WAIT, WARP_EXECUTE, WARP_UPDATE, WARP_DONE
  } warp_state_t;
endpackage

// Per-warp context: PC and halted/unused bit.
module warp_scheduler_ctx #(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic [PC_WIDTH-1:0] i_load_pc,
  input  logic                i_load_done,
  input  logic                i_upd,
  input  logic [PC_WIDTH-1:0] i_upd_pc,
  input  logic                i_halt,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic                o_done
);
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc   <= '0;
      r_done <= 1'b0;
    end else if (i_load) begin
      r_pc   <= i_load_pc;
      r_done <= i_load_done;
    end else begin
      if (i_upd)  r_pc   <= i_upd_pc;
      if (i_halt) r_done <= 1'b1;
    end
  end

  assign o_pc   = r_pc;
  assign o_done = r_done;
endmodule

module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int PC_WIDTH  = 32,
  parameter int PC_STEP   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [$clog2(NUM_WARPS):0]     warp_count,
  input  logic [PC_WIDTH-1:0]            base_pc,
  output logic                           fetch_valid,
  output logic [PC_WIDTH-1:0]            fetch_pc,
  input  logic                           fetch_ready,
  input  logic                           decoded_halt,
  input  logic                           decoded_mem_read_enable,
  input  logic                           decoded_mem_write_enable,
  output logic                           lsu_req,
  input  logic                           lsu_done,
  input  logic                           branch_taken,
  input  logic [PC_WIDTH-1:0]            branch_target,
  output warp_state_t                    warp_state,
  output logic [$clog2(NUM_WARPS)-1:0]   active_warp,
  output logic [NUM_WARPS-1:0]           warp_done_mask,
  output logic                           done
);
  localparam int WW = $clog2(NUM_WARPS);
  localparam int CW = WW + 1;

  warp_state_t                        r_state, w_next;
  logic [WW-1:0]                      r_active, w_grant;
  logic [PC_WIDTH-1:0]                r_fetch_pc, w_new_pc;
  logic                               r_done, w_start, w_all_done, w_mem;
  logic [NUM_WARPS-1:0][PC_WIDTH-1:0] w_pc;
  logic [NUM_WARPS-1:0]               w_mask, w_upd, w_halt, w_load_done;

  assign w_start    = start && (r_state == WARP_IDLE || r_state == WARP_DONE);
  assign w_mem      = decoded_mem_read_enable | decoded_mem_write_enable;
  assign w_new_pc   = branch_taken ? branch_target : w_pc[r_active] + PC_WIDTH'(PC_STEP);
  assign w_all_done = &w_mask;

  generate
    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
      assign w_load_done[g] = (CW'(g) >= warp_count);
      assign w_upd[g]  = (r_state == WARP_UPDATE)  && (r_active == WW'(g)) && !w_mask[g];
      assign w_halt[g] = (r_state == WARP_REQUEST) && (r_active == WW'(g)) && decoded_halt;

      warp_scheduler_ctx #(.PC_WIDTH(PC_WIDTH)) u_ctx (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_start),
        .i_load_pc   (base_pc),
        .i_load_done (w_load_done[g]),
        .i_upd       (w_upd[g]),
        .i_upd_pc    (w_new_pc),
        .i_halt      (w_halt[g]),
        .o_pc        (w_pc[g]),
        .o_done      (w_mask[g])
      );
    end
  endgenerate

  // Scan downward so the nearest eligible warp after r_active wins; k=NUM_WARPS
  // wraps back onto r_active, making the current warp eligible last.
  always_comb begin
    w_grant = r_active;
    for (int k = NUM_WARPS; k >= 1; k--) begin
      if (!w_mask[r_active + WW'(k)]) w_grant = r_active + WW'(k);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      WARP_IDLE, WARP_DONE:
        if (w_start) w_next = (warp_count == '0) ? WARP_DONE : WARP_FETCH;
      WARP_FETCH:   if (fetch_ready) w_next = WARP_DECODE;
      WARP_DECODE:  w_next = WARP_REQUEST;
      WARP_REQUEST: begin
        if (decoded_halt) w_next = WARP_UPDATE;
        else if (w_mem)   w_next = WARP_WAIT;
        else              w_next = WARP_EXECUTE;
      end
      WARP_WAIT:    if (lsu_done) w_next = WARP_EXECUTE;
      WARP_EXECUTE: w_next = WARP_UPDATE;
      WARP_UPDATE:  w_next = w_all_done ? WARP_DONE : WARP_FETCH;
      default:      w_next = WARP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= WARP_IDLE;
      r_active   <= '0;
      r_fetch_pc <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_active   <= '0;
        r_fetch_pc <= base_pc;
        r_done     <= (warp_count == '0);
      end else if (r_state == WARP_UPDATE) begin
        if (w_all_done) begin
          r_done <= 1'b1;
        end else begin
          r_active   <= w_grant;
          // The ctx PC write lands this same edge, so forward it on a self-regrant.
          r_fetch_pc <= (w_grant == r_active) ? w_new_pc : w_pc[w_grant];
        end
      end
    end
  end

  assign fetch_valid    = (r_state == WARP_FETCH);
  assign lsu_req        = (r_state == WARP_REQUEST) && !decoded_halt && w_mem;
  assign fetch_pc       = r_fetch_pc;
  assign warp_state     = r_state;
  assign active_warp    = r_active;
  assign warp_done_mask = w_mask;
  assign done           = r_done;
endmodule

// File: tb/tb_warp_scheduler.sv
// Randomized scoreboard bench for warp_scheduler: a reference model predicts
// each fetch (warp, PC, cycle, mask), each LSU request and each completion.
module tb_warp_scheduler;
  import warp_scheduler_pkg::*;
  localparam int NW = 4;
  localparam int PW = 32;
  localparam int AW = 2;

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [AW:0]   warp_count = '0;
  logic [PW-1:0] base_pc = '0, branch_target = '0;
  logic          fetch_ready = 1'b0, decoded_halt = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
  logic          lsu_done = 1'b0, branch_taken = 1'b0;
  logic          fetch_valid, lsu_req, done;
  logic [PW-1:0] fetch_pc;
  warp_state_t   warp_state;
  logic [AW-1:0] active_warp;
  logic [NW-1:0] warp_done_mask;

  warp_scheduler #(.NUM_WARPS(NW), .PC_WIDTH(PW), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset), .start(start), .warp_count(warp_count), .base_pc(base_pc),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .decoded_halt(decoded_halt), .decoded_mem_read_enable(rd_en),
    .decoded_mem_write_enable(wr_en), .lsu_req(lsu_req), .lsu_done(lsu_done),
    .branch_taken(branch_taken), .branch_target(branch_target), .warp_state(warp_state),
    .active_warp(active_warp), .warp_done_mask(warp_done_mask), .done(done)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction
  function automatic void flag(input string nm);
    n_chk++; n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endfunction

  // Reference model: per-warp PC/halt, rotating grant, expected events.
  typedef struct { bit is_done; int warp; logic [PW-1:0] pc; int cyc; logic [NW-1:0] mask; } exp_t;
  exp_t          exp_q[$];
  int            lsu_q[$];
  logic [PW-1:0] m_pc[NW];
  bit            m_halt[NW];
  int            m_cnt[NW];
  int            m_active = 0;
  bit            running = 0;
  int k_ready = 100, k_halt = 0, k_mem = 0, k_br = 0, k_brwarp = -1;
  int k_mind = 1, k_maxd = 1, k_maxi = 2;
  logic [PW-1:0] k_tgt = '0;

  function automatic logic [NW-1:0] mask_of();
    logic [NW-1:0] m;
    for (int i = 0; i < NW; i++) m[i] = m_halt[i];
    return m;
  endfunction

  // Environment: answers fetches with random instructions and advances the model.
  int pend = 0, cur_d = 1;
  always @(negedge clk) begin
    int w, lat, d, nxt, r;
    bit h, m, b;
    logic [PW-1:0] tg;
    if (!reset) begin
      pend = 0; fetch_ready = 0; lsu_done = 0; decoded_halt = 0;
      rd_en = 0; wr_en = 0; branch_taken = 0;
    end else begin
      fetch_ready = ($urandom_range(99) < k_ready);
      if (fetch_valid && fetch_ready && running) begin
        w = m_active;
        m_cnt[w]++;
        h  = (m_cnt[w] > k_maxi) || ($urandom_range(99) < k_halt);
        m  = ($urandom_range(99) < k_mem);
        d  = $urandom_range(k_maxd, k_mind);
        b  = ($urandom_range(99) < k_br) && (k_brwarp < 0 || k_brwarp == w);
        tg = (k_tgt != 0) ? k_tgt : ($urandom & 32'hFFFF_FFFC);
        r  = $urandom_range(3, 1);
        decoded_halt = h; rd_en = m && r[0]; wr_en = m && r[1];
        branch_taken = b; branch_target = tg; cur_d = d;
        if (h) m_halt[w] = 1;
        else   m_pc[w] = b ? tg : m_pc[w] + 32'd4;
        lat = h ? 4 : (m ? 5 + d : 5);
        if (m && !h) lsu_q.push_back(cyc + 2);
        if (&mask_of()) begin
          exp_q.push_back('{1'b1, 0, '0, cyc + lat, mask_of()});
          running = 0;
        end else begin
          nxt = w;
          for (int k = NW; k >= 1; k--) if (!m_halt[(w + k) % NW]) nxt = (w + k) % NW;
          m_active = nxt;
          exp_q.push_back('{1'b0, nxt, m_pc[nxt], cyc + lat, mask_of()});
        end
      end
      lsu_done = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) lsu_done = 1;
      end else if ($urandom_range(99) < 10) lsu_done = 1;
      if (lsu_req) pend = cur_d;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a fetch, LSU request or completion.
  bit p_fv = 0, p_done = 0;
  int cur_w = 0;
  logic [PW-1:0] cur_pc = '0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (fetch_valid && !p_fv) begin
        if (exp_q.size() == 0 || exp_q[0].is_done) flag("fetch_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("fetch_warp", active_warp, e.warp);
          chk("fetch_pc", fetch_pc, e.pc);
          chk("fetch_cycle", cyc, e.cyc);
          chk("fetch_mask", warp_done_mask, e.mask);
          cur_w = e.warp; cur_pc = e.pc;
        end
      end
      if (warp_state inside {WARP_DECODE, WARP_REQUEST, WARP_WAIT, WARP_EXECUTE, WARP_UPDATE}) begin
        chk("active_stable", active_warp, cur_w);
        chk("pc_stable", fetch_pc, cur_pc);
      end
      if (exp_q.size() != 0 && exp_q[0].is_done && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("done_flag", done, 1);
        chk("done_cycle", cyc, e.cyc);
        chk("done_state", warp_state, WARP_DONE);
        chk("done_mask", warp_done_mask, e.mask);
      end else if (done && !p_done) flag("done_early");
      if (lsu_req) begin
        if (lsu_q.size() == 0) flag("lsu_req_unexpected");
        else chk("lsu_req_cycle", cyc, lsu_q.pop_front());
      end
    end
    p_fv = fetch_valid; p_done = done;
  end

  task automatic start_run(input int cnt, input logic [PW-1:0] base);
    @(negedge clk);
    for (int i = 0; i < NW; i++) begin m_pc[i] = base; m_halt[i] = (i >= cnt); m_cnt[i] = 0; end
    m_active = 0;
    if (cnt == 0) exp_q.push_back('{1'b1, 0, '0, cyc + 1, mask_of()});
    else begin
      exp_q.push_back('{1'b0, 0, base, cyc + 1, mask_of()});
      running = 1;
    end
    start = 1; warp_count = AW'(0) | (AW+1)'(cnt); base_pc = base;
    @(negedge clk);
    start = 0; warp_count = (AW+1)'($urandom); base_pc = $urandom;
  endtask

  // Waits for the model to finish, injecting starts that must be ignored mid-run.
  task automatic wait_drain(input int limit);
    int n = 0;
    while ((running || exp_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
      if (running && $urandom_range(99) < 5) begin
        start = 1; warp_count = (AW+1)'($urandom_range(NW)); base_pc = $urandom;
      end else start = 0;
    end
    start = 0;
    chk("drain_timeout", (running || exp_q.size() != 0 || lsu_q.size() != 0), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_state"}, warp_state, WARP_IDLE);
    chk({nm, "_fetch_valid"}, fetch_valid, 0);
    chk({nm, "_lsu_req"}, lsu_req, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_mask"}, warp_done_mask, 0);
    chk({nm, "_fetch_pc"}, fetch_pc, 0);
    chk({nm, "_active"}, active_warp, 0);
  endtask

  initial begin
    int waited;
    // Reset held low while inputs toggle.
    repeat (6) begin
      @(negedge clk);
      start = 1'($urandom); warp_count = (AW+1)'($urandom); base_pc = $urandom;
      #1 check_reset_vals("reset_hold");
    end
    @(negedge clk); start = 0; reset = 1;

    // Two warps, ALU only, fetch_ready tied high: 0,1,0,1 every 5 cycles.
    k_ready = 100; k_halt = 0; k_mem = 0; k_br = 0; k_maxi = 2;
    start_run(2, 32'h100); wait_drain(300);
    // Memory op with lsu_done three cycles after lsu_req.
    k_mem = 100; k_mind = 3; k_maxd = 3; k_maxi = 1;
    start_run(1, 32'h300); wait_drain(300);
    // Branch on warp 1 only.
    k_mem = 0; k_br = 100; k_brwarp = 1; k_tgt = 32'h200; k_maxi = 2;
    start_run(2, 32'h100); wait_drain(300);
    k_br = 0; k_brwarp = -1; k_tgt = '0;
    // All four halt on their first instruction, then an empty launch.
    k_maxi = 0;
    start_run(4, 32'h80); wait_drain(300);
    start_run(0, 32'h80); wait_drain(50);
    // PC wrap past 2^32.
    k_maxi = 3;
    start_run(1, 32'hFFFF_FFF8); wait_drain(300);

    for (int run = 0; run < 12; run++) begin
      k_ready = $urandom_range(100, 40); k_halt = $urandom_range(15);
      k_mem = $urandom_range(60); k_br = $urandom_range(40);
      k_mind = 1; k_maxd = $urandom_range(5, 1); k_maxi = $urandom_range(6, 1);
      start_run($urandom_range(NW, 1), $urandom & 32'hFFFF_FFFC);
      wait_drain(3000);
    end

    // Reset while waiting on the LSU, then relaunch.
    k_ready = 100; k_mem = 100; k_halt = 0; k_br = 0; k_mind = 10; k_maxd = 10; k_maxi = 3;
    start_run(2, 32'h500);
    waited = 0;
    while (!lsu_req && waited < 100) begin @(negedge clk); waited++; end
    chk("wait_for_lsu_req", lsu_req, 1);
    repeat (2) @(negedge clk);
    #2 reset = 0;
    #1 check_reset_vals("reset_mid_wait");
    exp_q.delete(); lsu_q.delete(); running = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    k_mem = 0; k_mind = 1; k_maxd = 1; k_maxi = 1;
    start_run(1, 32'h40); wait_drain(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
